// File: rtl/uart_cmd_sequencer.sv
// Parses SYNC/ADDR/DATA/CHK packets from a UART receiver byte stream and
// offers each checksum-valid packet downstream as a register-write command.
module uart_cmd_sequencer #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 27800
) (
  input  logic       i_uart_clk,
  input  logic       i_reset_n,
  input  logic [7:0] i_byte_in,
  input  logic       i_data_valid,
  output logic       o_rx_ready,
  output logic       o_wr_valid,
  input  logic       i_wr_ready,
  output logic [7:0] o_wr_addr,
  output logic [7:0] o_wr_data,
  output logic       o_chk_err,
  output logic       o_timeout,
  output logic [7:0] o_err_cnt,
  output logic       o_busy
);

  localparam int unsigned   CW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, GET_ADDR, GET_DATA, GET_CHK, ISSUE} state_t;

  state_t        state, state_next;
  logic [CW-1:0] tmo_cnt, tmo_next;
  logic          accept, in_get, tmo_fire;
  logic          chk_err_next, timeout_next;
  logic [7:0]    chk_exp;

  // A byte is taken only once per receiver handshake and never while a write is pending.
  assign accept   = i_data_valid && !o_rx_ready && (state != ISSUE);
  assign in_get   = (state == GET_ADDR) || (state == GET_DATA) || (state == GET_CHK);
  assign tmo_fire = in_get && !accept && (tmo_cnt == TMO_LAST);
  assign chk_exp  = o_wr_addr + o_wr_data;

  assign o_wr_valid = (state == ISSUE);
  assign o_busy     = (state != IDLE);

  always_comb begin
    state_next   = state;
    chk_err_next = 1'b0;
    timeout_next = 1'b0;
    tmo_next     = '0;
    if (in_get && !accept && !tmo_fire) begin
      tmo_next = tmo_cnt + 1'b1;
    end
    case (state)
      IDLE:     if (accept && (i_byte_in == SYNC_BYTE)) state_next = GET_ADDR;
      GET_ADDR: if (accept) state_next = GET_DATA;
      GET_DATA: if (accept) state_next = GET_CHK;
      GET_CHK: begin
        if (accept) begin
          if (i_byte_in == chk_exp) begin
            state_next = ISSUE;
          end else begin
            state_next   = IDLE;
            chk_err_next = 1'b1;
          end
        end
      end
      ISSUE:    if (i_wr_ready) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
    // tmo_fire already excludes an accepted byte, so acceptance wins a tie.
    if (tmo_fire) begin
      state_next   = IDLE;
      timeout_next = 1'b1;
    end
  end

  always_ff @(posedge i_uart_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state     <= IDLE;
      tmo_cnt   <= '0;
      o_chk_err <= 1'b0;
      o_timeout <= 1'b0;
    end else begin
      state     <= state_next;
      tmo_cnt   <= tmo_next;
      o_chk_err <= chk_err_next;
      o_timeout <= timeout_next;
    end
  end

  always_ff @(posedge i_uart_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_rx_ready <= 1'b0;
      o_wr_addr  <= '0;
      o_wr_data  <= '0;
      o_err_cnt  <= '0;
    end else begin
      if (accept) begin
        o_rx_ready <= 1'b1;
      end else if (o_rx_ready && !i_data_valid) begin
        o_rx_ready <= 1'b0;
      end
      if (accept && (state == GET_ADDR)) o_wr_addr <= i_byte_in;
      if (accept && (state == GET_DATA)) o_wr_data <= i_byte_in;
      if ((o_chk_err || o_timeout) && (o_err_cnt != 8'hFF)) begin
        o_err_cnt <= o_err_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Self-checking bench for uart_cmd_sequencer: directed packet scenarios plus
// randomized packet streams checked against a packet-level reference model.
module tb_uart_cmd_sequencer;

  localparam int unsigned TMO = 200;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] byte_in = 8'h00;
  logic       data_valid = 1'b0;
  logic       rx_ready;
  logic       wr_valid;
  logic       wr_ready = 1'b0;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       chk_err;
  logic       timeout;
  logic [7:0] err_cnt;
  logic       busy;

  uart_cmd_sequencer #(
    .SYNC_BYTE      (8'hA5),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .i_uart_clk   (clk),
    .i_reset_n    (rst_n),
    .i_byte_in    (byte_in),
    .i_data_valid (data_valid),
    .o_rx_ready   (rx_ready),
    .o_wr_valid   (wr_valid),
    .i_wr_ready   (wr_ready),
    .o_wr_addr    (wr_addr),
    .o_wr_data    (wr_data),
    .o_chk_err    (chk_err),
    .o_timeout    (timeout),
    .o_err_cnt    (err_cnt),
    .o_busy       (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int chk_seen = 0;
  int tmo_seen = 0;
  int stab_err = 0;
  int err_exp = 0;
  int ready_mode = 0;  // 0: hold low, 1: random, 2: always high
  logic [15:0] got_q[$];
  logic [15:0] exp_q[$];
  logic        prev_valid = 1'b0;
  logic [15:0] prev_cmd = 16'h0;

  // Observer: counts pulses, records accepted writes, watches command stability.
  always @(negedge clk) begin
    if (chk_err) chk_seen++;
    if (timeout) tmo_seen++;
    if (wr_valid && prev_valid && ({wr_addr, wr_data} !== prev_cmd)) stab_err++;
    prev_valid = wr_valid;
    prev_cmd   = {wr_addr, wr_data};
    if (wr_valid && wr_ready) got_q.push_back({wr_addr, wr_data});
  end

  always begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       wr_ready = 1'b0;
      1:       wr_ready = ($urandom_range(0, 2) == 0);
      default: wr_ready = 1'b1;
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    byte_in    = b;
    data_valid = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (!rx_ready && n < 400);
    if (!rx_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_byte_ack byte=%02h rx_ready=0 expected 1 within 400 cycles", b);
    end
    data_valid = 1'b0;
    step();
  endtask

  task automatic send_pkt(input logic [7:0] a, input logic [7:0] d, input logic [7:0] c);
    send_byte(8'hA5);
    send_byte(a);
    send_byte(d);
    send_byte(c);
  endtask

  task automatic wait_writes(input int k);
    int n;
    n = 0;
    while (got_q.size() < k && n < 400) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    n_cmp++; if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL reset_rx_ready got %0b want 0", rx_ready); end
    n_cmp++; if (wr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wr_valid got %0b want 0", wr_valid); end
    n_cmp++; if ({wr_addr, wr_data} !== 16'h0) begin n_fail++; $display("FAIL reset_cmd got %04h want 0000", {wr_addr, wr_data}); end
    n_cmp++; if ({chk_err, timeout, busy} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %03b want 000", {chk_err, timeout, busy}); end
    n_cmp++; if (err_cnt !== 8'h00) begin n_fail++; $display("FAIL reset_err_cnt got %02h want 00", err_cnt); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_good_packet();
    ready_mode = 2;
    send_pkt(8'h10, 8'h22, 8'h32);
    wait_writes(1);
    n_cmp++;
    if (got_q.size() == 0) begin
      n_fail++; $display("FAIL good_write got none want 1022");
    end else begin
      if (got_q[0] !== 16'h1022) begin n_fail++; $display("FAIL good_write got %04h want 1022", got_q[0]); end
      void'(got_q.pop_front());
    end
    n_cmp++; if (err_cnt !== 8'(err_exp)) begin n_fail++; $display("FAIL good_err_cnt got %0d want %0d", err_cnt, err_exp); end
  endtask

  task automatic test_chk_err();
    int c0;
    c0 = chk_seen;
    send_pkt(8'h10, 8'h22, 8'h33);
    err_exp = (err_exp < 255) ? err_exp + 1 : 255;
    repeat (5) step();
    n_cmp++; if (chk_seen - c0 !== 1) begin n_fail++; $display("FAIL chk_err_pulses got %0d want 1", chk_seen - c0); end
    n_cmp++; if (err_cnt !== 8'(err_exp)) begin n_fail++; $display("FAIL chk_err_cnt got %0d want %0d", err_cnt, err_exp); end
    n_cmp++; if (got_q.size() !== 0) begin n_fail++; $display("FAIL chk_no_write got %0d writes want 0", got_q.size()); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL chk_idle busy got %0b want 0", busy); end
  endtask

  task automatic test_junk_prefix();
    send_byte(8'h00);
    send_byte(8'hFF);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL junk_busy got %0b want 0", busy); end
    send_pkt(8'h01, 8'h02, 8'h03);
    wait_writes(1);
    n_cmp++;
    if (got_q.size() == 0) begin
      n_fail++; $display("FAIL junk_write got none want 0102");
    end else begin
      if (got_q[0] !== 16'h0102) begin n_fail++; $display("FAIL junk_write got %04h want 0102", got_q[0]); end
      void'(got_q.pop_front());
    end
    n_cmp++; if (err_cnt !== 8'(err_exp)) begin n_fail++; $display("FAIL junk_err_cnt got %0d want %0d", err_cnt, err_exp); end
  endtask

  task automatic test_timeout();
    int n, t0;
    t0 = tmo_seen;
    send_byte(8'hA5);
    send_byte(8'h10);
    n = 0;
    while (!timeout && n < int'(TMO) + 20) begin
      step();
      n++;
    end
    n_cmp++;
    if (!timeout || n < int'(TMO) - 3 || n > int'(TMO) + 2) begin
      n_fail++; $display("FAIL timeout_delay got %0d cycles (seen=%0b) want about %0d", n, timeout, TMO);
    end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL timeout_busy got %0b want 0", busy); end
    err_exp = (err_exp < 255) ? err_exp + 1 : 255;
    repeat (4) step();
    n_cmp++; if (tmo_seen - t0 !== 1) begin n_fail++; $display("FAIL timeout_pulses got %0d want 1", tmo_seen - t0); end
    n_cmp++; if (err_cnt !== 8'(err_exp)) begin n_fail++; $display("FAIL timeout_err_cnt got %0d want %0d", err_cnt, err_exp); end
    send_pkt(8'h44, 8'h55, 8'h99);
    wait_writes(1);
    n_cmp++;
    if (got_q.size() == 0) begin
      n_fail++; $display("FAIL timeout_next_write got none want 4455");
    end else begin
      if (got_q[0] !== 16'h4455) begin n_fail++; $display("FAIL timeout_next_write got %04h want 4455", got_q[0]); end
      void'(got_q.pop_front());
    end
  endtask

  task automatic test_back_to_back();
    int viol, n;
    ready_mode = 0;
    step();
    send_pkt(8'h55, 8'h66, 8'hBB);
    byte_in    = 8'hA5;
    data_valid = 1'b1;
    viol = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (rx_ready !== 1'b0 || wr_valid !== 1'b1) viol++;
    end
    n_cmp++; if (viol !== 0) begin n_fail++; $display("FAIL backpressure_hold got %0d bad cycles want 0", viol); end
    ready_mode = 2;
    n = 0;
    while (!rx_ready && n < 50) begin
      step();
      n++;
    end
    n_cmp++; if (rx_ready !== 1'b1) begin n_fail++; $display("FAIL backpressure_release rx_ready got %0b want 1", rx_ready); end
    data_valid = 1'b0;
    step();
    n_cmp++;
    if (got_q.size() == 0) begin
      n_fail++; $display("FAIL backpressure_write got none want 5566");
    end else begin
      if (got_q[0] !== 16'h5566) begin n_fail++; $display("FAIL backpressure_write got %04h want 5566", got_q[0]); end
      void'(got_q.pop_front());
    end
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    wait_writes(1);
    n_cmp++;
    if (got_q.size() == 0) begin
      n_fail++; $display("FAIL held_pkt_write got none want 0102");
    end else begin
      if (got_q[0] !== 16'h0102) begin n_fail++; $display("FAIL held_pkt_write got %04h want 0102", got_q[0]); end
      void'(got_q.pop_front());
    end
  endtask

  task automatic test_random();
    int kind, nj, bad, c0;
    logic [7:0] a, d, c, j;
    bad = 0;
    c0 = chk_seen;
    ready_mode = 1;
    for (int p = 0; p < 40; p++) begin
      kind = $urandom_range(0, 3);
      a = 8'($urandom);
      d = 8'($urandom);
      if (kind == 3) begin
        nj = $urandom_range(1, 3);
        for (int k = 0; k < nj; k++) begin
          j = 8'($urandom);
          if (j == 8'hA5) j = 8'h5A;
          send_byte(j);
        end
      end
      if (kind == 2) begin
        c = a + d + 8'($urandom_range(1, 255));
        bad++;
        err_exp = (err_exp < 255) ? err_exp + 1 : 255;
      end else begin
        c = a + d;
        exp_q.push_back({a, d});
      end
      send_pkt(a, d, c);
    end
    wait_writes(exp_q.size());
    ready_mode = 2;
    repeat (4) step();
    n_cmp++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL rand_write_count got %0d want %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      n_cmp++;
      if (got_q[0] !== exp_q[0]) begin n_fail++; $display("FAIL rand_write got %04h want %04h", got_q[0], exp_q[0]); end
      void'(got_q.pop_front());
      void'(exp_q.pop_front());
    end
    got_q.delete();
    exp_q.delete();
    n_cmp++; if (chk_seen - c0 !== bad) begin n_fail++; $display("FAIL rand_chk_pulses got %0d want %0d", chk_seen - c0, bad); end
    n_cmp++; if (err_cnt !== 8'(err_exp)) begin n_fail++; $display("FAIL rand_err_cnt got %0d want %0d", err_cnt, err_exp); end
  endtask

  task automatic test_saturate();
    logic [7:0] a, d;
    ready_mode = 2;
    for (int i = 0; i < 300; i++) begin
      a = 8'($urandom);
      d = 8'($urandom);
      send_pkt(a, d, a + d + 8'd1);
      err_exp = (err_exp < 255) ? err_exp + 1 : 255;
    end
    repeat (4) step();
    n_cmp++; if (err_cnt !== 8'(err_exp)) begin n_fail++; $display("FAIL sat_err_cnt got %0d want %0d", err_cnt, err_exp); end
    n_cmp++; if (err_cnt !== 8'hFF) begin n_fail++; $display("FAIL sat_err_cnt_max got %0d want 255", err_cnt); end
  endtask

  task automatic test_reset_mid_packet();
    int n;
    send_byte(8'hA5);
    send_byte(8'h10);
    byte_in    = 8'hA5;
    data_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({rx_ready, wr_valid, chk_err, timeout, busy} !== 5'b0) begin n_fail++; $display("FAIL mid_reset_flags got %05b want 00000", {rx_ready, wr_valid, chk_err, timeout, busy}); end
    n_cmp++; if ({wr_addr, wr_data} !== 16'h0) begin n_fail++; $display("FAIL mid_reset_cmd got %04h want 0000", {wr_addr, wr_data}); end
    n_cmp++; if (err_cnt !== 8'h00) begin n_fail++; $display("FAIL mid_reset_err_cnt got %0d want 0", err_cnt); end
    err_exp = 0;
    step();
    step();
    #2;
    rst_n = 1'b1;
    n = 0;
    while (!rx_ready && n < 20) begin
      step();
      n++;
    end
    n_cmp++; if (rx_ready !== 1'b1) begin n_fail++; $display("FAIL mid_reset_held_ack rx_ready got %0b want 1", rx_ready); end
    data_valid = 1'b0;
    step();
    send_byte(8'h33);
    send_byte(8'h44);
    send_byte(8'h77);
    wait_writes(1);
    n_cmp++;
    if (got_q.size() == 0) begin
      n_fail++; $display("FAIL mid_reset_write got none want 3344");
    end else begin
      if (got_q[0] !== 16'h3344) begin n_fail++; $display("FAIL mid_reset_write got %04h want 3344", got_q[0]); end
      void'(got_q.pop_front());
    end
    n_cmp++; if (stab_err !== 0) begin n_fail++; $display("FAIL cmd_stable got %0d changes want 0", stab_err); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_good_packet();
    test_chk_err();
    test_junk_prefix();
    test_timeout();
    test_back_to_back();
    test_random();
    test_saturate();
    test_reset_mid_packet();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_cmd_sequencer.md
UART_CMD_SEQUENCER -- requirements
Module: uart_cmd_sequencer

Interface
REQ-001 The block SHALL have parameter SYNC_BYTE, default 8'hA5, the packet start marker.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 27800, the inter-byte timeout in clocks (about 20 byte times at BAUD_MULT 139).
REQ-003 Port i_uart_clk  in  1  is the single clock; the block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 Port i_reset_n  in  1  is the asynchronous active-low reset.
REQ-005 Port i_byte_in  in  8  is the received byte from the UART receiver.
REQ-006 Port i_data_valid  in  1  is high while the receiver holds a byte for pickup.
REQ-007 Port o_rx_ready  out  1  is the pickup acknowledge to the receiver.
REQ-008 Port o_wr_valid  out  1  is high while a register-write command is offered.
REQ-009 Port i_wr_ready  in  1  is the downstream acceptance of the write command.
REQ-010 Ports o_wr_addr  out  8  and o_wr_data  out  8  carry the command; both SHALL be stable while o_wr_valid=1.
REQ-011 Ports o_chk_err  out  1  and o_timeout  out  1  are single-cycle error pulses.
REQ-012 Port o_err_cnt  out  8  is a saturating error counter.
REQ-013 Port o_busy  out  1  SHALL be high whenever the state is not IDLE.

Function
REQ-014 Packet format SHALL be SYNC_BYTE, ADDR, DATA, CHK, with CHK = (ADDR + DATA) mod 256.
REQ-015 A byte SHALL be accepted in a cycle only when i_data_valid=1, o_rx_ready=0 and state is not ISSUE.
REQ-016 o_rx_ready SHALL rise the cycle after acceptance, stay high until i_data_valid is sampled 0, then fall on the next cycle.
REQ-017 No second acceptance SHALL occur while o_rx_ready=1.
REQ-018 The state machine SHALL have the states IDLE, GET_ADDR, GET_DATA, GET_CHK and ISSUE.
REQ-019 In IDLE, an accepted byte equal to SYNC_BYTE SHALL move the FSM to GET_ADDR; any other byte SHALL be acknowledged and discarded with no error.
REQ-020 GET_ADDR SHALL latch ADDR and move to GET_DATA; GET_DATA SHALL latch DATA and move to GET_CHK.
REQ-021 In GET_CHK, a matching CHK SHALL move the FSM to ISSUE with o_wr_valid=1 on the next cycle.
REQ-022 In GET_CHK, a mismatching CHK SHALL pulse o_chk_err for 1 cycle and return the FSM to IDLE.
REQ-023 In ISSUE, o_wr_valid SHALL hold until sampled with i_wr_ready=1; the FSM SHALL then go to IDLE with o_wr_valid=0 on the next cycle.
REQ-024 While in ISSUE, incoming bytes SHALL NOT be acknowledged; the receiver is backpressured and holds its byte.
REQ-025 A timeout counter SHALL clear on every accepted byte and on entry to IDLE, and SHALL count only in GET_ADDR, GET_DATA and GET_CHK.
REQ-026 When the counter reaches TIMEOUT_CYCLES-1, the FSM SHALL go to IDLE and o_timeout SHALL pulse for 1 cycle.
REQ-027 If a byte is accepted in the same cycle the timeout would fire, byte acceptance SHALL win and no timeout SHALL occur.
REQ-028 o_err_cnt SHALL increment by 1 per o_chk_err or o_timeout pulse and SHALL saturate at 255.
REQ-029 A SYNC_BYTE value received in ADDR, DATA or CHK position SHALL be treated as ordinary data.

Reset
REQ-030 Reset assertion SHALL force, asynchronously: state IDLE, o_rx_ready=0, o_wr_valid=0, o_wr_addr=0, o_wr_data=0, o_chk_err=0, o_timeout=0, o_err_cnt=0, o_busy=0, timeout counter=0.
REQ-031 Reset mid-packet SHALL abandon the partial packet; a receiver byte still held valid after release SHALL be accepted normally from IDLE.

Verification
REQ-032 Bytes A5,10,22,32 then i_wr_ready=1 -> one o_wr_valid with addr 8'h10 and data 8'h22; o_err_cnt stays 0.
REQ-033 Bytes A5,10,22,33 -> o_chk_err pulses 1 cycle; o_err_cnt=1; no o_wr_valid; FSM returns to IDLE.
REQ-034 Bytes 00,FF,A5,01,02,03 -> leading 00 and FF are discarded; write with addr 01 and data 02 is issued.
REQ-035 A5,10 then silence for TIMEOUT_CYCLES -> o_timeout pulses once; o_busy=0; a following valid packet completes.
REQ-036 Valid packet with i_wr_ready=0 for 50 cycles while the next byte is held valid -> o_rx_ready stays 0 until the write is accepted; the next byte is then acknowledged.
REQ-037 Force 300 checksum errors -> o_err_cnt=255; reset asserted mid-packet -> all outputs return to their REQ-030 values within the same cycle.
